affine_addr_gen: RTL and testbench

AFFINE_ADDR_GEN -- requirements
Module: affine_addr_gen

---
 rtl/affine_addr_gen_if.sv | 27 ++
 rtl/affine_addr_gen.sv | 86 ++++++++
 tb/tb_affine_addr_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/affine_addr_gen_if.sv
// affine_addr_gen_if: scan request/config and address stream bundle.
// AFFINE_ADDR_GEN_BOUNDS_EN adds limit/addr_err.
interface affine_addr_gen_if #(parameter int WIDTH = 32, parameter int DIMS = 3);
    logic                   start;
    logic [WIDTH-1:0]       offset;
    logic [DIMS*WIDTH-1:0]  extent;
    logic [DIMS*WIDTH-1:0]  stride;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       addr;
    logic                   last;
    logic                   done;
`ifdef AFFINE_ADDR_GEN_BOUNDS_EN
    logic [WIDTH-1:0]       limit;
    logic                   addr_err;
    modport master(input start, offset, extent, stride, out_ready, limit,
                   output busy, out_valid, addr, last, done, addr_err);
    modport slave(output start, offset, extent, stride, out_ready, limit,
                  input busy, out_valid, addr, last, done, addr_err);
`else
    modport master(input start, offset, extent, stride, out_ready,
                   output busy, out_valid, addr, last, done);
    modport slave(output start, offset, extent, stride, out_ready,
                  input busy, out_valid, addr, last, done);
`endif
endinterface

// File: rtl/affine_addr_gen.sv
// affine_addr_gen: nested-loop affine address generator, addr = offset + sum(idx[d]*stride[d]).
// AFFINE_ADDR_GEN_BOUNDS_EN adds a latched limit and an addr_err flag.
module affine_addr_gen #(
    parameter int WIDTH = 32,
    parameter int DIMS  = 3
) (
    input logic               clk,
    input logic               rst,
    affine_addr_gen_if.master bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                        state, state_nxt;
    logic [DIMS-1:0][WIDTH-1:0]    ext_r, str_r, idx, acc, em1;
    logic [WIDTH-1:0]              off_r, sum;
    logic [DIMS-1:0]               wrap, step;
    logic                          run, accept, fire, last, done_r;
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        run       = state == RUN;
        accept    = !run && bus.start;
        fire      = run && bus.out_ready;
        last      = run && &wrap;
        state_nxt = accept ? RUN : (fire && last) ? IDLE : state;
    end
    for (genvar d = 0; d < DIMS; d++) begin : g_dim
        // extent 0 behaves as 1, so the terminal index is 0 either way
        assign em1[d]  = (ext_r[d] == '0) ? '0 : ext_r[d] - ONE;
        assign wrap[d] = idx[d] == em1[d];
        if (d == 0) begin : g_lo
            assign step[d] = fire;
        end else begin : g_hi
            assign step[d] = fire && &wrap[d-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            off_r  <= '0;
            ext_r  <= '0;
            str_r  <= '0;
            idx    <= '0;
            acc    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= fire && last;
            if (accept) begin
                off_r <= bus.offset;
                ext_r <= bus.extent;
                str_r <= bus.stride;
                idx   <= '0;
                acc   <= '0;
            end else begin
                for (int d = 0; d < DIMS; d++)
                    if (step[d]) begin
                        idx[d] <= wrap[d] ? '0 : idx[d] + ONE;
                        acc[d] <= wrap[d] ? '0 : acc[d] + str_r[d];
                    end
            end
        end
    end
    always_comb begin
        sum = off_r;
        for (int d = 0; d < DIMS; d++)
            sum = sum + acc[d];
    end
    assign bus.busy      = run;
    assign bus.out_valid = run;
    assign bus.addr      = sum;
    assign bus.last      = last;
    assign bus.done      = done_r;
`ifdef AFFINE_ADDR_GEN_BOUNDS_EN
    logic [WIDTH-1:0] limit_r;
    always_ff @(posedge clk) begin
        if (rst)
            limit_r <= '0;
        else if (accept)
            limit_r <= bus.limit;
    end
    assign bus.addr_err = run && (sum >= limit_r);
`endif
endmodule

// File: tb/tb_affine_addr_gen.sv
// tb_affine_addr_gen: directed checks of scan order, stalls, wrap-around, reset abort.
module tb_affine_addr_gen;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_q[$];
    always #5 clk = ~clk;
    affine_addr_gen_if #(.WIDTH(32), .DIMS(2)) bus ();
    affine_addr_gen #(.WIDTH(32), .DIMS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic config_start(input logic [31:0] off, e0, e1, s0, s1);
        bus.start  = 1'b1;
        bus.offset = off;
        bus.extent = {e1, e0};
        bus.stride = {s1, s0};
`ifdef AFFINE_ADDR_GEN_BOUNDS_EN
        bus.limit  = 32'd160;
`endif
    endtask
    task automatic scan(input logic [31:0] off, e0, e1, s0, s1, input bit stall);
        int k = 0;
        int cyc = 0;
        config_start(off, e0, e1, s0, s1);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.offset = 32'hdead_beef;
        bus.extent = '1;
        bus.stride = '1;
        while (k < exp_q.size() && cyc < 200) begin
            bus.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            bus.start = (cyc == 2);
            check("valid", 32'(bus.out_valid), 32'd1);
            check("addr", bus.addr, exp_q[k]);
            check("last", 32'(bus.last), 32'(k == exp_q.size() - 1));
`ifdef AFFINE_ADDR_GEN_BOUNDS_EN
            check("addr_err", 32'(bus.addr_err), 32'(exp_q[k] >= 32'd160));
`endif
            if (bus.out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        check("count", 32'(k), 32'(exp_q.size()));
        check("done", 32'(bus.done), 32'd1);
        check("busy_end", 32'(bus.busy), 32'd0);
        check("valid_end", 32'(bus.out_valid), 32'd0);
    endtask
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        bus.offset = '0;
        bus.extent = '0;
        bus.stride = '0;
`ifdef AFFINE_ADDR_GEN_BOUNDS_EN
        bus.limit = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_last", 32'(bus.last), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_addr", bus.addr, 32'd0);
`ifdef AFFINE_ADDR_GEN_BOUNDS_EN
        check("rst_err", 32'(bus.addr_err), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        exp_q = '{32'd100, 32'd104, 32'd108, 32'd164, 32'd168, 32'd172};
        scan(32'd100, 32'd3, 32'd2, 32'd4, 32'd64, 1'b0);
        scan(32'd100, 32'd3, 32'd2, 32'd4, 32'd64, 1'b1);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        exp_q = '{32'd7};
        scan(32'd7, 32'd0, 32'd1, 32'd5, 32'd9, 1'b0);
        @(negedge clk);
        exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
        scan(32'hFFFF_FFF0, 32'd4, 32'd1, 32'd8, 32'd0, 1'b0);
        @(negedge clk);
        config_start(32'd100, 32'd3, 32'd2, 32'd4, 32'd64);
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_a0", bus.addr, 32'd100);
        @(negedge clk);
        check("abort_a1", bus.addr, 32'd104);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_addr", bus.addr, 32'd0);
        config_start(32'd100, 32'd3, 32'd2, 32'd4, 32'd64);
        @(negedge clk);
        check("rst_prio", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_nodone", 32'(bus.done), 32'd0);
        exp_q = '{32'd100, 32'd104, 32'd108, 32'd164, 32'd168, 32'd172};
        scan(32'd100, 32'd3, 32'd2, 32'd4, 32'd64, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
